// File: rtl/psdsqrt.sv
// psdsqrt: sequential 32-bit integer square root, one result bit per clock, MSB first
module psdsqrt (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] x,
  output logic [15:0] sqrt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] xr, tw, sq;
  logic [15:0] root, mask, trial;
  assign trial = root | mask;
  assign tw = {16'd0, trial};
  assign sq = tw * tw;
  // the mask reaching its last bit marks the 16th iteration
  always_comb state_n = start ? RUN : (state == RUN && mask == 16'd1) ? DONE : state;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sqrt <= '0;
      root <= '0;
      mask <= '0;
      xr <= '0;
    end else begin
      state <= state_n;
      if (stop) sqrt <= root;
      if (start) begin
        xr <= x;
        root <= '0;
        mask <= 16'h8000;
      end else if (state == RUN) begin
        if (xr >= sq) root <= trial;
        mask <= mask >> 1;
      end
    end
  end
endmodule

// File: tb/tb_psdsqrt.sv
// tb_psdsqrt: scoreboard bench comparing psdsqrt against an arithmetic floor-sqrt model
module tb_psdsqrt;
  logic clock = 0, reset = 1, start = 0, stop = 0, chk = 0;
  logic [31:0] x = '0;
  logic [15:0] sqrt, held;
  logic [15:0] q[$];
  int checks = 0, errors = 0;

  psdsqrt dut (.clock(clock), .reset(reset), .start(start), .stop(stop), .x(x), .sqrt(sqrt));

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual running, required finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    longint lo = 0, hi = 65536, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= longint'(v)) lo = mid; else hi = mid;
    end
    return lo[15:0];
  endfunction

  // root after n iterations: the top n bits of floor(sqrt(v))
  function automatic logic [15:0] expv(input logic [31:0] v, input int n);
    logic [15:0] r = isqrt(v);
    if (n < 16) r = r & ~((16'd1 << (16 - n)) - 16'd1);
    return r;
  endfunction

  always @(posedge clock) begin
    logic c;
    logic [15:0] e;
    c = chk;
    #1;
    if (c) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: sqrt=%0d with no expected value queued", sqrt);
      end else begin
        e = q.pop_front();
        if (sqrt !== e) begin
          errors++;
          $display("FAIL sqrt: actual %0d (0x%h), required %0d (0x%h)", sqrt, sqrt, e, e);
        end
      end
    end
  end

  task automatic read_hold();
    chk = 1; q.push_back(held);
    @(negedge clock) chk = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clock) reset = 0;
    held = '0;
  endtask

  // start on xv, then stop on edge n+1 after the start edge
  task automatic run(input logic [31:0] xv, input int n, input logic [15:0] e);
    start = 1; x = xv;
    @(negedge clock) start = 0; x = $urandom;
    repeat (n) @(negedge clock);
    stop = 1; chk = 1; q.push_back(e); held = e;
    @(negedge clock) stop = 0; chk = 0;
  endtask

  logic [31:0] dx [10] = '{0, 1, 3, 4, 65535, 65536, 32'd4294836224, 32'd4294836225, 32'hFFFFFFFF, 123456};
  logic [15:0] de [10] = '{0, 1, 1, 2, 255, 256, 65534, 65535, 65535, 351};

  initial begin
    logic [31:0] rx;
    int n;
    held = '0;
    @(negedge clock);
    do_reset();
    read_hold();
    for (int i = 0; i < 10; i++) run(dx[i], 16, de[i]);
    run(100, 16, 10);
    start = 1; x = 99;
    @(negedge clock) start = 0; x = 32'hDEADBEEF;
    repeat (8) @(negedge clock);
    read_hold();
    repeat (8) @(negedge clock);
    stop = 1; chk = 1; q.push_back(9); held = 9;
    @(negedge clock) stop = 0; chk = 0;
    read_hold();
    start = 1; x = 123456;
    repeat (5) @(negedge clock);
    start = 0;
    do_reset();
    stop = 1; chk = 1; q.push_back(0);
    @(negedge clock) stop = 0; chk = 0;
    run(123456, 16, 351);
    run(32'hFFFFFFFF, 4, 16'hF000);
    run(1000000, 20, 1000);
    start = 1; stop = 1; chk = 1; x = 2500; q.push_back(1000);
    @(negedge clock) start = 0; stop = 0; chk = 0; x = $urandom;
    repeat (16) @(negedge clock);
    stop = 1; chk = 1; q.push_back(50);
    @(negedge clock) stop = 0; chk = 0;
    for (int i = 0; i < 2000; i++) begin
      rx = (i % 4 == 0) ? ($urandom & 32'hFFFF) : $urandom;
      n = (i % 8 == 7) ? $urandom_range(0, 15) : $urandom_range(16, 18);
      run(rx, n, expv(rx, n));
    end
    repeat (3) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected values left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
